// File: rtl/vga_timing_gen.sv
// Raster timing generator: H/V counts, sync pulses, active flag and line/frame markers, advanced on i_Pix_En.
// Optional completed-frame counter o_Frame_num is present only when VGA_FRAME_NUM_EN is defined.
module vga_timing_gen #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0,
  parameter int   FRAME_W    = 8,
  localparam int  HTOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  VTOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  HW         = $clog2(HTOTAL),
  localparam int  VW         = $clog2(VTOTAL)
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_Pix_En,
  input  logic               i_Restart,
  output logic [HW-1:0]      o_H_count,
  output logic [VW-1:0]      o_V_count,
  output logic               o_HSync,
  output logic               o_VSync,
  output logic               o_Active,
  output logic               o_Line_end,
  output logic               o_Frame_end,
`ifdef VGA_FRAME_NUM_EN
  output logic [FRAME_W-1:0] o_Frame_num,
`endif
  output logic               o_Frame_start
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);

  state_e        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          active_q, active_d;
  logic          line_end_q, line_end_d;
  logic          frame_end_q, frame_end_d;
  logic          frame_start_q, frame_start_d;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    if (i_Restart) begin
      state_d = IDLE;
      h_d     = '0;
      v_d     = '0;
    end else if (i_Pix_En) begin
      // The first enable out of IDLE only primes the decode of (0,0).
      if (state_q == IDLE) begin
        state_d = RUN;
      end else if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Flags decode the next position so they always line up with the registered counts.
  always_comb begin
    hsync_d       = ~H_SYNC_POL;
    vsync_d       = ~V_SYNC_POL;
    active_d      = 1'b0;
    line_end_d    = 1'b0;
    frame_end_d   = 1'b0;
    frame_start_d = 1'b0;
    if (state_d == RUN) begin
      if ((int'(h_d) >= H_ACTIVE + H_FP) && (int'(h_d) < H_ACTIVE + H_FP + H_SYNC))
        hsync_d = H_SYNC_POL;
      if ((int'(v_d) >= V_ACTIVE + V_FP) && (int'(v_d) < V_ACTIVE + V_FP + V_SYNC))
        vsync_d = V_SYNC_POL;
      active_d      = (int'(h_d) < H_ACTIVE) && (int'(v_d) < V_ACTIVE);
      line_end_d    = (h_d == H_LAST);
      frame_end_d   = (h_d == H_LAST) && (v_d == V_LAST);
      frame_start_d = (h_d == '0) && (v_d == '0);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q       <= IDLE;
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
      active_q      <= 1'b0;
      line_end_q    <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      line_end_q    <= line_end_d;
      frame_end_q   <= frame_end_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_FRAME_NUM_EN
  logic               frame_wrap;
  logic [FRAME_W-1:0] frame_num_q, frame_num_d;

  assign frame_wrap  = (state_q == RUN) && i_Pix_En && !i_Restart &&
                       (h_q == H_LAST) && (v_q == V_LAST);
  assign frame_num_d = i_Restart ? '0 : (frame_num_q + FRAME_W'(frame_wrap));

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) frame_num_q <= '0;
    else          frame_num_q <= frame_num_d;
  end

  assign o_Frame_num = frame_num_q;
`endif

  assign o_H_count     = h_q;
  assign o_V_count     = v_q;
  assign o_HSync       = hsync_q;
  assign o_VSync       = vsync_q;
  assign o_Active      = active_q;
  assign o_Line_end    = line_end_q;
  assign o_Frame_end   = frame_end_q;
  assign o_Frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator for the Pong video path. Produces horizontal/vertical pixel counts, sync pulses with configurable polarity, an active-video flag and line/frame markers, advancing only on a pixel-clock enable. It sits between the clock/enable source and the paddle, ball and pixel-mux logic, and replaces the fixed 800x525 frame counter.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_SYNC_POL, 0, asserted level of o_HSync
- V_SYNC_POL, 0, asserted level of o_VSync
- FRAME_W, 8, width of o_Frame_num
- Derived: HTOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; VTOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; HW = $clog2(HTOTAL); VW = $clog2(VTOTAL)

- i_Clk  in  1  system clock; the only clock
- i_Rst_n  in  1  asynchronous, active-low reset
- i_Pix_En  in  1  pixel-advance enable; the block changes state only on enabled edges, except for i_Restart
- i_Restart  in  1  synchronous restart to the post-reset state
- o_H_count  out  HW  current pixel column
- o_V_count  out  VW  current line
- o_HSync  out  1  horizontal sync, polarity H_SYNC_POL
- o_VSync  out  1  vertical sync, polarity V_SYNC_POL
- o_Active  out  1  pixel is in the visible area
- o_Line_end  out  1  o_H_count == HTOTAL-1
- o_Frame_end  out  1  last pixel of the frame
- o_Frame_start  out  1  first pixel of the frame
- o_Frame_num  out  FRAME_W  completed-frame counter (macro only)

## Operation
- FSM with two states:
  - IDLE: entered on reset or i_Restart.
  - RUN: entered on the first i_Pix_En in IDLE. That enable loads the decode of position (0,0) without advancing the counts.
- In RUN, each enabled edge advances the count:
  - H increments.
  - When H == HTOTAL-1: H wraps to 0, and V increments, or wraps to 0 at VTOTAL-1.
- All outputs are registered and decoded from the new position on the same edge, so the decode flags always match o_H_count/o_V_count.
- Horizontal regions, in order: active [0, H_ACTIVE-1], front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], back porch. The vertical regions follow the same scheme using the V parameters.
- o_HSync = H_SYNC_POL inside the H sync range, ~H_SYNC_POL otherwise. o_VSync works the same way on V, so it changes only when H wraps to 0.
- o_Active = (H < H_ACTIVE) && (V < V_ACTIVE).
- o_Frame_start = (H==0 && V==0) in RUN. o_Frame_end = (H==HTOTAL-1 && V==VTOTAL-1).
- Outputs are levels held between enables. Consumers that need single-clock pulses qualify them with i_Pix_En.
- Restart and reset behaviour:
  - i_Restart has priority over i_Pix_En.
  - Asserting i_Restart mid-frame returns the block to IDLE on the next edge.
  - Reset asserted mid-operation forces IDLE asynchronously.

## Timing
- Reset/IDLE values: counts 0, o_HSync = ~H_SYNC_POL, o_VSync = ~V_SYNC_POL, o_Active 0, o_Line_end 0, o_Frame_end 0, o_Frame_start 0, o_Frame_num 0.
- Latency: 1 clock from an enabled edge to the updated count and decode.
- With i_Pix_En tied high, the frame period is exactly HTOTAL*VTOTAL clocks, plus 1 priming clock after reset or restart.
- Wrap at (HTOTAL-1, VTOTAL-1) → (0,0) happens on a single enabled edge: o_Frame_end drops and o_Frame_start rises on the same edge.

## Configuration
- VGA_FRAME_NUM_EN:
  - Defined: o_Frame_num is present. It increments modulo 2^FRAME_W on each (HTOTAL-1, VTOTAL-1) → (0,0) wrap. It is cleared by reset and by i_Restart.
  - Undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
Small configuration for all scenarios: H=4/1/2/1 (HTOTAL 8), V=3/1/1/1 (VTOTAL 6), polarities 0, i_Pix_En high unless noted.
- Reset release:
  - Cycle 1: counts (0,0), o_Active=1, o_Frame_start=1, syncs 1.
  - Cycle 2: H=1.
- Horizontal sync: o_HSync = 0 exactly at H=5,6 on every line; o_Line_end = 1 only at H=7; V increments at the H 7→0 edge.
- Vertical sync and frame wrap:
  - o_VSync = 0 for all H on V=4 only.
  - At (7,5): o_Frame_end=1; next edge gives (0,0) with o_Frame_start=1, and frame period = 48 clocks.
- Enable gating: i_Pix_En high every 3rd clock → counts and flags hold for 2 clocks between advances; frame period = 144 clocks.
- i_Restart asserted at (3,2) while i_Pix_En=1 → next clock shows IDLE values; the following enable gives (0,0).
- Frame number (VGA_FRAME_NUM_EN defined, FRAME_W=2): after 5 complete frames o_Frame_num = 1 (wraps 3→0); async reset mid-frame clears it immediately.
